// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_master
// Purpose  : Command-driven JTAG master. Each accepted command produces a
//            TCK pulse train with matching TMS/TDI values, walking the target
//            TAP from Run-Test/Idle through a DR or IR scan and back. It can
//            also issue a TAP reset or a run of idle clocks. Out of reset the
//            TAP reset sequence runs once before the first command is taken.
// Ports    : clk, rst             - system clock, synchronous active-high reset
//            cmd_valid/cmd_ready  - command handshake
//            cmd_op               - 00 DR scan, 01 IR scan, 10 TAP reset,
//                                   11 idle clocks
//            cmd_len              - bit count minus one (N = cmd_len + 1)
//            cmd_data             - TDI bits, LSB shifted first
//            rsp_valid/rsp_data   - one-cycle completion pulse + captured TDO
//            busy                 - high whenever the controller is not idle
//            tck/tms/tdi, tdo     - JTAG pins toward the target TAP
// Revision : 1.0 - initial release
// ============================================================================
module jtag_master #(
  parameter int CLK_DIV = 2  // clk cycles per TCK half-period, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_len,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam logic [1:0] OP_DR   = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  // Divider terminal count: the last clk cycle of either TCK phase.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RST_SEQ = 3'd0,
    IDLE    = 3'd1,
    PRE     = 3'd2,
    SHIFT   = 3'd3,
    POST    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic [7:0]  div_q,       div_d;       // clk count inside the current phase
  logic [3:0]  pulse_q,     pulse_d;     // pulse index inside the current state
  logic [1:0]  op_q,        op_d;
  logic [3:0]  len_q,       len_d;
  logic [15:0] data_q,      data_d;
  logic [15:0] cap_q,       cap_d;       // TDO bits gathered during SHIFT
  logic        tck_q,       tck_d;
  logic        tms_q,       tms_d;
  logic        tdi_q,       tdi_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q,  rsp_data_d;
  logic        busy_q,      busy_d;

  // --------------------------------------------------------------------------
  // Sequence tables
  // --------------------------------------------------------------------------
  // Index of the final pulse a state issues before moving on.
  function automatic logic [3:0] last_pulse(input state_t st, input logic [1:0] op,
                                            input logic [3:0] len);
    logic [3:0] idx;
    idx = 4'd0;
    case (st)
      RST_SEQ: idx = 4'd5;
      PRE: begin
        case (op)
          OP_DR:   idx = 4'd2;
          OP_IR:   idx = 4'd3;
          OP_RST:  idx = 4'd5;
          default: idx = len;            // idle clocks: N pulses
        endcase
      end
      SHIFT:   idx = len;
      POST:    idx = 4'd1;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // TMS level for pulse idx of state st.
  //   PRE  DR: 1,0,0        (Select-DR, Capture-DR, Shift-DR)
  //   PRE  IR: 1,1,0,0      (Select-DR, Select-IR, Capture-IR, Shift-IR)
  //   SHIFT  : 0 ... 0,1    (last bit leaves through Exit1)
  //   POST   : 1,0          (Update, Run-Test/Idle)
  //   reset  : 1,1,1,1,1,0  (Test-Logic-Reset, then Run-Test/Idle)
  function automatic logic tms_for(input state_t st, input logic [1:0] op,
                                   input logic [3:0] len, input logic [3:0] idx);
    logic v;
    v = 1'b0;
    case (st)
      RST_SEQ: v = (idx != 4'd5);
      PRE: begin
        case (op)
          OP_DR:   v = (idx == 4'd0);
          OP_IR:   v = (idx < 4'd2);
          OP_RST:  v = (idx != 4'd5);
          default: v = 1'b0;
        endcase
      end
      SHIFT:   v = (idx == len);
      POST:    v = (idx == 4'd0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  state_t     seq_next;    // state that follows the current pulse sequence
  logic [3:0] pulse_inc;
  logic       div_end;
  logic       is_last;

  always_comb begin
    case (state_q)
      PRE:     seq_next = (op_q == OP_DR || op_q == OP_IR) ? SHIFT : DONE;
      SHIFT:   seq_next = POST;
      default: seq_next = DONE;
    endcase
  end

  assign pulse_inc = pulse_q + 4'd1;
  assign div_end   = (div_q == DIV_LAST);
  assign is_last   = (pulse_q == last_pulse(state_q, op_q, len_q));

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pulse_d     = pulse_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          len_d       = cmd_len;
          data_d      = cmd_data;
          cap_d       = 16'h0000;
          state_d     = PRE;
          pulse_d     = 4'd0;
          div_d       = 8'd0;
          tck_d       = 1'b0;
          // First low phase starts now, so its TMS level is presented here.
          tms_d       = tms_for(PRE, cmd_op, cmd_len, 4'd0);
          tdi_d       = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        tck_d       = 1'b0;
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
      end

      default: begin
        // RST_SEQ, PRE, SHIFT, POST: shared TCK pulse engine.
        if (!div_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!tck_q) begin
            // End of low phase: TCK rises; the target's TDO is stable here.
            tck_d = 1'b1;
            if (state_q == SHIFT) begin
              cap_d[pulse_q] = tdo;
            end
          end else begin
            // End of high phase: TCK falls and the next pulse's TMS/TDI
            // are presented in the same edge.
            tck_d = 1'b0;
            if (is_last) begin
              pulse_d = 4'd0;
              state_d = seq_next;
              if (seq_next == DONE) begin
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (state_q == POST) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = cap_q;
                end
              end else begin
                tms_d = tms_for(seq_next, op_q, len_q, 4'd0);
                tdi_d = (seq_next == SHIFT) ? data_q[0] : 1'b0;
              end
            end else begin
              pulse_d = pulse_inc;
              tms_d   = tms_for(state_q, op_q, len_q, pulse_inc);
              tdi_d   = (state_q == SHIFT) ? data_q[pulse_inc] : 1'b0;
            end
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. Reset parks the engine in the first low cycle of the
  // TAP reset sequence, so TMS is already 1 while rst is held.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_SEQ;
      div_q       <= 8'd0;
      pulse_q     <= 4'd0;
      op_q        <= 2'b00;
      len_q       <= 4'd0;
      data_q      <= 16'h0000;
      cap_q       <= 16'h0000;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pulse_q     <= pulse_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule
`default_nettype wire
